// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer
//   Captures architectural register writes from the core's write-back stage into a FIFO.
//   The FIFO drains to a host or debug consumer over a valid/ready handshake. The block also
//   keeps a running checksum of accepted data and overflow/drop statistics.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   wb_valid   core retires a register write this cycle
//   wb_rd      destination register index
//   wb_data    write-back data
//   clear      synchronous flush of FIFO, statistics and checksum
//   out_valid  head entry available
//   out_ready  consumer accepts the head entry this cycle
//   out_data   {rd, data} of the head entry; zero when empty
//   level      current occupancy, 0..DEPTH
//   overflow   sticky flag: at least one write was dropped
//   drop_cnt   count of dropped writes, saturating
//   checksum   sum mod 2^DATA_W of the data of all accepted writes
module wb_trace_buffer #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned FILTER_X0 = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wb_valid,
    input  logic [4:0]               wb_rd,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W+4:0]        out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [15:0]              drop_cnt,
    output logic [DATA_W-1:0]        checksum
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned ENT_W = DATA_W + 5;

    typedef enum logic [0:0] {StEmpty, StNonEmpty} state_e;

    state_e                   state_q, state_d;
    logic [ENT_W-1:0]         mem_q [DEPTH];
    logic [ENT_W-1:0]         mem_d [DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]         level_q, level_d;
    logic                     overflow_q, overflow_d;
    logic [15:0]              drop_cnt_q, drop_cnt_d;
    logic [DATA_W-1:0]        checksum_q, checksum_d;

    logic push_req;
    logic pop;
    logic full;
    logic push_ok;
    logic drop;

    // Writes to x0 never reach the FIFO when filtering is enabled.
    assign push_req = wb_valid && !((FILTER_X0 != 0) && (wb_rd == 5'd0));
    assign pop      = out_valid && out_ready;
    assign full     = (level_q == LVL_W'(DEPTH));
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        drop_cnt_d  = drop_cnt_q;
        checksum_d  = checksum_q;

        if (clear) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_d[i] = '0;
            end
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
            checksum_d = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = {wb_rd, wb_data};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
                checksum_d      = checksum_q + wb_data;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push_ok, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end
            end
        end

        state_d = (level_d != '0) ? StNonEmpty : StEmpty;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StEmpty;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            checksum_q <= checksum_d;
        end
    end

    assign out_valid = (state_q == StNonEmpty);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;
    assign checksum  = checksum_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer with hand-computed expectations.
module tb_wb_trace_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        clear;
    logic        out_valid;
    logic        out_ready;
    logic [36:0] out_data;
    logic [4:0]  level;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic [31:0] checksum;

    int n_cmp = 0;
    int n_bad = 0;

    wb_trace_buffer #(
        .DATA_W    (32),
        .DEPTH     (16),
        .FILTER_X0 (1)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n, input logic [4:0] rd, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            wb_valid = 1'b1;
            wb_rd    = rd;
            wb_data  = base + 32'(i);
            tick();
        end
        wb_valid = 1'b0;
    endtask

    task automatic pop_n(input int n);
        out_ready = 1'b1;
        repeat (n) tick();
        out_ready = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        wb_valid  = 1'b1;
        wb_rd     = 5'd3;
        wb_data   = 32'h1234;
        clear     = 1'b0;
        out_ready = 1'b0;

        // 1: reset held with a live write
        tick();
        tick();
        check("rst_valid", out_valid, 0);
        check("rst_level", level, 0);
        check("rst_csum", checksum, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_ovf", overflow, 0);
        check("rst_data", out_data, 0);
        wb_valid = 1'b0;
        reset    = 1'b1;
        tick();
        check("post_rst_level", level, 0);

        // 2: single write, one-cycle latency to head
        wb_valid = 1'b1;
        wb_rd    = 5'd5;
        wb_data  = 32'hAA;
        tick();
        wb_valid = 1'b0;
        check("single_valid", out_valid, 1);
        check("single_data", out_data, {5'd5, 32'hAA});
        check("single_level", level, 1);
        check("single_csum", checksum, 32'hAA);
        pop_n(1);
        check("single_drained", out_valid, 0);
        check("single_empty_data", out_data, 0);
        do_clear();
        check("clr_csum", checksum, 0);

        // 3: fill to overflow, then drain in order
        push_n(18, 5'd1, 32'd1);
        check("fill_level", level, 16);
        check("fill_ovf", overflow, 1);
        check("fill_drop", drop_cnt, 2);
        check("fill_csum", checksum, 136);
        tick();
        check("hold_data", out_data, {5'd1, 32'd1});
        for (int i = 1; i <= 16; i++) begin
            check("drain_valid", out_valid, 1);
            check("drain_data", out_data, {5'd1, 32'(i)});
            pop_n(1);
        end
        check("drain_empty", out_valid, 0);
        check("drain_level", level, 0);

        // 4: full with simultaneous push and pop
        do_clear();
        push_n(16, 5'd1, 32'd1);
        check("full_level", level, 16);
        wb_valid  = 1'b1;
        wb_rd     = 5'd4;
        wb_data   = 32'h77;
        out_ready = 1'b1;
        tick();
        wb_valid  = 1'b0;
        out_ready = 1'b0;
        check("pp_level", level, 16);
        check("pp_drop", drop_cnt, 0);
        check("pp_ovf", overflow, 0);
        check("pp_csum", checksum, 32'hFF);
        check("pp_head", out_data, {5'd1, 32'd2});
        pop_n(15);
        check("pp_last", out_data, {5'd4, 32'h77});
        pop_n(1);
        check("pp_empty", out_valid, 0);

        // 5: x0 filter and checksum wrap
        do_clear();
        wb_valid = 1'b1;
        wb_rd    = 5'd0;
        wb_data  = 32'hFFFF_FFFF;
        tick();
        wb_valid = 1'b0;
        check("x0_level", level, 0);
        check("x0_csum", checksum, 0);
        check("x0_valid", out_valid, 0);
        push_n(1, 5'd2, 32'hFFFF_FFFF);
        check("wrap_pre", checksum, 32'hFFFF_FFFF);
        push_n(1, 5'd2, 32'd2);
        check("wrap_csum", checksum, 32'h1);
        check("wrap_level", level, 2);

        // 6a: synchronous clear with a concurrent push
        do_clear();
        push_n(17, 5'd6, 32'd10);
        pop_n(9);
        check("pre_clr_level", level, 7);
        check("pre_clr_ovf", overflow, 1);
        clear    = 1'b1;
        wb_valid = 1'b1;
        wb_rd    = 5'd3;
        wb_data  = 32'd5;
        tick();
        clear    = 1'b0;
        wb_valid = 1'b0;
        check("clr_level", level, 0);
        check("clr_csum2", checksum, 0);
        check("clr_ovf", overflow, 0);
        check("clr_drop", drop_cnt, 0);
        check("clr_valid", out_valid, 0);

        // 6b: async reset between edges
        push_n(17, 5'd6, 32'd10);
        pop_n(9);
        check("pre_rst_level", level, 7);
        #2;
        reset = 1'b0;
        #1;
        check("arst_level", level, 0);
        check("arst_valid", out_valid, 0);
        check("arst_csum", checksum, 0);
        check("arst_ovf", overflow, 0);
        check("arst_data", out_data, 0);
        reset = 1'b1;
        tick();
        push_n(1, 5'd7, 32'h55);
        check("after_arst_data", out_data, {5'd7, 32'h55});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
